riscv_mc_controller: RTL and testbench
======================================

# riscv_mc_controller

Multicycle control unit for the RV32I datapath: decodes the latched instruction fields, sequences each instruction through a Moore state machine, and drives every datapath enable and mux select. It produces the 4-bit `ALUControl` consumed by the ALU and reads back its `Flags` bus to resolve branches. It also keeps a retired-instruction counter and a sticky illegal-opcode trap.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `Flags` in 4: `{N, Z, C, V}` from the ALU, used combinationally.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 selects PC; 1 selects Result.
- `MemWrite` out 1: data memory write strobe.
- `IRWrite` out 1: enable for the instruction register and the OldPC register.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: 00 selects ALUOut, 01 selects Data, 10 selects ALUResult.
- `ALUSrcA` out 2: 00 selects PC, 01 selects OldPC, 10 selects rs1 data.
- `ALUSrcB` out 2: 00 selects rs2 data, 01 selects imm, 10 selects constant 4.
- `ImmSrc` out 3: immediate format. 000 I, 001 S, 010 B, 011 U (raw `instr[31:12]`), 100 J.
- `ALUControl` out 4: ALU operation code.
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT, 0110 SLL, 0111 SRL.
  - 1000 XOR, 1001 SLTU, 1010 SRA, 1011 LUI (B<<12), 1100 AUIPC (A+(B<<12)).
- `illegal` out 1: sticky trap indicator.
- `instret` out 32: count of retired instructions.

## Operation
- **Moore FSM.** All outputs decode from the state only, except `PCWrite` in BRANCH. Unlisted outputs are 0. `ImmSrc` is decoded from `op` in every state.
- **RST:** all outputs 0. Next state is FETCH.
- **FETCH:** `AdrSrc`=0, `IRWrite`=1, A=00, B=10, ADD, `ResultSrc`=10, `PCWrite`=1. Next state is DECODE.
- **DECODE:** A=01, B=01, ADD (branch/jump target latched into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH, but only if `funct3` is in {000, 001, 100, 101}; otherwise ILLEGAL.
  - 1101111 → JAL.
  - 0110111 → LUI.
  - 0010111 → AUIPC.
  - Anything else → ILLEGAL.
- **MEMADR:** A=10, B=01, ADD. Next state is MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD:** `ResultSrc`=00, `AdrSrc`=1. Next state is MEMWB.
- **MEMWB:** `ResultSrc`=01, `RegWrite`=1. Next state is FETCH.
- **MEMWRITE:** `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1. Next state is FETCH.
- **EXECR:** A=10, B=00, ALU op from the funct decode. Next state is ALUWB.
- **EXECI:** A=10, B=01, ALU op from the funct decode. Next state is ALUWB.
- **JAL:** A=01, B=10, ADD, `ResultSrc`=00, `PCWrite`=1. Next state is ALUWB.
- **LUI:** B=01, `ALUControl`=1011. Next state is ALUWB.
- **AUIPC:** A=01, B=01, `ALUControl`=1100. Next state is ALUWB.
- **ALUWB:** `ResultSrc`=00, `RegWrite`=1. Next state is FETCH.
- **BRANCH:** A=10, B=00, SUB, `ResultSrc`=00. `PCWrite` equals the taken condition:
  - `funct3` 000 (beq): Z.
  - 001 (bne): !Z.
  - 100 (blt): N^V.
  - 101 (bge): !(N^V).
  - Next state is FETCH.
- **ILLEGAL:** all outputs 0, `illegal`=1. The FSM stays here until `reset`.
- **Funct decode** by `funct3`:
  - 000: SUB when `op`=0110011 and `funct7b5`=1; ADD otherwise (ADDI ignores `funct7b5`).
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRA if `funct7b5`=1, else SRL.
  - 110 OR, 111 AND.
- **`instret`:** increments by 1, modulo 2^32, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps from FFFFFFFF to 0.

## Timing
- **Reset:** `reset` high forces state RST, all outputs 0, `illegal`=0 and `instret`=0, immediately and asynchronously. This holds mid-instruction too: no partial `RegWrite` or `MemWrite` may appear after `reset` asserts. FETCH is the first state on the second rising edge after deassertion.
- **Cycles per instruction, FETCH through the last state:**
  - Load: 5.
  - Store, R-type, I-type, JAL, LUI, AUIPC: 4.
  - Branch: 3.
- **`Flags`:** sampled in the same cycle as BRANCH. It is never registered.
- **`instret` latency:** the new value is visible on the edge that enters FETCH.

## Test plan
- **Reset/idle:** assert `reset` mid-MEMWRITE.
  - `MemWrite` drops to 0 asynchronously; all outputs read 0.
  - After release: RST, then FETCH with `IRWrite`=1, `PCWrite`=1, B=10.
- **Load:** `op`=0000011.
  - States FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - `RegWrite`=1 only in cycle 5 with `ResultSrc`=01.
  - `instret` goes 0 → 1.
- **R-type decode sweep:** all 8 `funct3` values with `funct7b5`=0/1.
  - EXECR shows the expected codes, e.g. 000/1 → 0001, 101/1 → 1010.
  - I-type 000/1 → 0000.
- **Branches:**
  - beq with Z=1 → `PCWrite`=1 in BRANCH.
  - bne with Z=1 → 0.
  - blt with `Flags`=1001 → 0 (N^V=0).
  - bge with `Flags`=1000 → 0 (N^V=1).
  - Each branch takes 3 cycles.
- **Illegal:**
  - `op`=1111111 → ILLEGAL after DECODE.
  - `illegal`=1, with no further FETCH, for 20 cycles until `reset`.
  - Branch with `funct3`=010 also traps.
- **Counter wrap:** preload via 2^32−1 retirements (force), then one ALU op → `instret`=0.

Source files
------------

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller
// Multicycle RV32I control unit. A Moore FSM walks each instruction through
// FETCH/DECODE/execute/writeback states and drives every datapath enable and
// mux select. The ALU operation is decoded from funct3/funct7b5, branches are
// resolved from the ALU Flags in the BRANCH state, retired instructions are
// counted in instret, and an unknown opcode parks the FSM in a sticky trap.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   op, funct3, funct7b5 instruction fields from the instruction register
//   Flags                {N, Z, C, V} from the ALU, used combinationally
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite       datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl    datapath mux/op codes
//   illegal              high while trapped on an illegal instruction
//   instret              retired-instruction count (wraps modulo 2^32)
//   state                current FSM state, exposed for observation

module riscv_mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [3:0]  Flags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_LUI      = 4'd10,
    S_AUIPC    = 4'd11,
    S_ALUWB    = 4'd12,
    S_BRANCH   = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_LUI   = 4'b1011;
  localparam logic [3:0] ALU_AUIPC = 4'b1100;

  state_t      state_q, state_d;
  logic        rst_seen_q;   // set on the first edge after reset release
  logic [31:0] instret_q;
  logic [2:0]  imm_dec;
  logic [3:0]  alu_funct;
  logic        branch_ok;
  logic        taken;
  logic        flag_n, flag_z, flag_v;
  logic        flags_c_unused;

  assign flag_n         = Flags[3];
  assign flag_z         = Flags[2];
  assign flag_v         = Flags[0];
  assign flags_c_unused = Flags[1];

  // Immediate format follows the opcode alone.
  always_comb begin
    imm_dec = 3'b000;
    case (op)
      OP_LOAD, OP_ITYPE: imm_dec = 3'b000;
      OP_STORE:          imm_dec = 3'b001;
      OP_BRANCH:         imm_dec = 3'b010;
      OP_LUI, OP_AUIPC:  imm_dec = 3'b011;
      OP_JAL:            imm_dec = 3'b100;
      default:           imm_dec = 3'b000;
    endcase
  end

  // funct decode shared by EXECR and EXECI; only register-register ops use
  // funct7b5 to select SUB, since ADDI carries immediate bits there.
  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3)
      3'b000:  alu_funct = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_funct = ALU_SLL;
      3'b010:  alu_funct = ALU_SLT;
      3'b011:  alu_funct = ALU_SLTU;
      3'b100:  alu_funct = ALU_XOR;
      3'b101:  alu_funct = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_funct = ALU_OR;
      default: alu_funct = ALU_AND;
    endcase
  end

  // Supported branches and their taken condition from the SUB flags.
  always_comb begin
    branch_ok = 1'b0;
    taken     = 1'b0;
    case (funct3)
      3'b000: begin branch_ok = 1'b1; taken = flag_z;               end
      3'b001: begin branch_ok = 1'b1; taken = !flag_z;              end
      3'b100: begin branch_ok = 1'b1; taken = flag_n ^ flag_v;      end
      3'b101: begin branch_ok = 1'b1; taken = !(flag_n ^ flag_v);   end
      default: begin branch_ok = 1'b0; taken = 1'b0;                end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RST;
      rst_seen_q <= 1'b0;
      instret_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      rst_seen_q <= 1'b1;
      // These states always retire into FETCH on this edge.
      if (state_q == S_MEMWB || state_q == S_MEMWRITE ||
          state_q == S_ALUWB || state_q == S_BRANCH)
        instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    // RST and ILLEGAL drive every output to zero, ImmSrc included.
    ImmSrc     = (state_q == S_RST || state_q == S_ILLEGAL) ? 3'b000 : imm_dec;
    case (state_q)
      S_RST: begin
        // Hold RST for one edge after release so FETCH lands on the second.
        state_d = rst_seen_q ? S_FETCH : S_RST;
      end
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = branch_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_funct;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_funct;
        state_d    = S_ALUWB;
      end
      S_JAL: begin
        // Link value OldPC+4 is computed here while PC takes ALUOut (target).
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_LUI;
        state_d    = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_AUIPC;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = taken;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_ILLEGAL;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Bench for riscv_mc_controller. Each instruction is described by its class
// and a cycle index within it; the expected control word for every cycle is
// built from that and queued, and a negedge process checks the DUT against
// the queue. A few literal expectations pin the model.

module tb_riscv_mc_controller;

  localparam int W = 51;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4;
  localparam int K_JAL = 5, K_LUI = 6, K_AUIPC = 7, K_ILL = 8;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [3:0]  Flags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state;

  riscv_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Flags(Flags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal), .instret(instret),
    .state(state)
  );

  logic [W-1:0] act;
  assign act = {instret, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [31:0]  instret_m;
  bit           trapped;
  logic [3:0]   cap_alu[8];
  logic         cap_pcw[8];
  logic         cap_rw[8];
  logic         cap_mw[8];
  logic [1:0]   cap_rs[8];
  logic [31:0]  cap_inst[8];

  task automatic check(input string name, input logic [W-1:0] a,
                       input logic [W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, act, e);
    end
  end

  // ---------------- reference model ----------------
  function automatic int kind_of(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5)
                         ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int len_of(input int k);
    case (k)
      K_LOAD:  return 5;
      K_BR:    return 3;
      K_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1101111:             return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  // ALU op for arithmetic instructions, named by mnemonic.
  function automatic logic [3:0] arith_of(input logic [2:0] f3, input logic f7,
                                          input bit is_r);
    case (f3)
      3'd0: return (is_r && f7) ? 4'b0001 : 4'b0000;   // sub : add
      3'd1: return 4'b0110;                            // sll
      3'd2: return 4'b0101;                            // slt
      3'd3: return 4'b1001;                            // sltu
      3'd4: return 4'b1000;                            // xor
      3'd5: return f7 ? 4'b1010 : 4'b0111;             // sra : srl
      3'd6: return 4'b0011;                            // or
      default: return 4'b0010;                         // and
    endcase
  endfunction

  function automatic bit taken_of(input logic [2:0] f3, input logic [3:0] fl);
    bit n, z, v;
    n = fl[3]; z = fl[2]; v = fl[0];
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n != v;
      default: return n == v;
    endcase
  endfunction

  function automatic logic [18:0] exp_ctrl(input int k, input int c,
      input logic [6:0] o, input logic [2:0] f3, input logic f7,
      input logic [3:0] fl);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, a, b;
    logic [3:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; a = 0; b = 0; alu = 0;
    if (c == 0) begin
      irw = 1; pcw = 1; b = 2; rs = 2;
    end else if (c == 1) begin
      a = 1; b = 1;
    end else begin
      case (k)
        K_LOAD: if (c == 2) begin a = 2; b = 1; end
                else if (c == 3) adr = 1;
                else begin rs = 1; rw = 1; end
        K_STORE: if (c == 2) begin a = 2; b = 1; end
                 else begin adr = 1; mw = 1; end
        K_R: if (c == 2) begin a = 2; alu = arith_of(f3, f7, 1); end
             else rw = 1;
        K_I: if (c == 2) begin a = 2; b = 1; alu = arith_of(f3, f7, 0); end
             else rw = 1;
        K_JAL: if (c == 2) begin a = 1; b = 2; pcw = 1; end
               else rw = 1;
        K_LUI: if (c == 2) begin b = 1; alu = 4'b1011; end
               else rw = 1;
        K_AUIPC: if (c == 2) begin a = 1; b = 1; alu = 4'b1100; end
                 else rw = 1;
        K_BR: begin a = 2; alu = 4'b0001; pcw = taken_of(f3, fl); end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, rw, rs, a, b, imm_of(o), alu, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [18:0] ctrl, input string t);
    exp_q.push_back({instret_m, ctrl});
    tag_q.push_back(t);
  endtask

  // Run one instruction; stop > 0 cuts it short after that many cycles.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [3:0] fl,
                           input int stop, input string t);
    int k, n;
    k = kind_of(o, f3);
    n = (stop > 0) ? stop : len_of(k);
    for (int c = 0; c < n; c++) begin
      tick();
      if (c == 0) begin
        op = o; funct3 = f3; funct7b5 = f7;
      end
      Flags = fl;
      push(exp_ctrl(k, c, o, f3, f7, fl), $sformatf("%s_c%0d", t, c));
      #1;
      cap_alu[c] = ALUControl; cap_pcw[c] = PCWrite; cap_rw[c] = RegWrite;
      cap_mw[c] = MemWrite; cap_rs[c] = ResultSrc; cap_inst[c] = instret;
    end
    if (k == K_ILL) trapped = 1;
    else if (stop == 0) instret_m = instret_m + 32'd1;
  endtask

  task automatic idle(input int n, input string t);
    for (int i = 0; i < n; i++) begin
      tick();
      push(trapped ? 19'd1 : 19'd0, t);
    end
  endtask

  task automatic assert_reset(input string t);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check({t, "_async"}, act, '0);
    repeat (2) @(negedge clk);
    #1 check({t, "_hold"}, act, '0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    instret_m = 32'd0;
    trapped = 0;
    tick();
    push(19'd0, "rst_state");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Flags = 4'd0;
    instret_m = 32'd0; trapped = 0;
    #1 check("por_zero", act, '0);
    release_reset();

    // load: 5 cycles, writeback only in the last one
    run_instr(7'b0000011, 3'd2, 1'b0, 4'd0, 0, "load");
    check("load_rw_c3", {50'd0, cap_rw[3]}, 51'd0);
    check("load_rw_c4", {50'd0, cap_rw[4]}, 51'd1);
    check("load_rs_c4", {49'd0, cap_rs[4]}, 51'd1);

    // addi with funct7b5 set still adds; instret now shows the load
    run_instr(7'b0010011, 3'd0, 1'b1, 4'd0, 0, "addi_f7");
    check("addi_alu", {47'd0, cap_alu[2]}, 51'd0);
    check("instret_after_load", {19'd0, cap_inst[0]}, 51'd1);

    for (int f = 0; f < 8; f++)
      for (int s = 0; s < 2; s++)
        run_instr(7'b0110011, f[2:0], s[0], 4'd0, 0, $sformatf("r_%0d_%0d", f, s));
    run_instr(7'b0110011, 3'd0, 1'b1, 4'd0, 0, "sub");
    check("sub_alu", {47'd0, cap_alu[2]}, 51'd1);
    run_instr(7'b0110011, 3'd5, 1'b1, 4'd0, 0, "sra");
    check("sra_alu", {47'd0, cap_alu[2]}, 51'd10);
    run_instr(7'b0010011, 3'd5, 1'b1, 4'd0, 0, "srai");
    run_instr(7'b0010011, 3'd3, 1'b0, 4'd0, 0, "sltiu");

    run_instr(7'b0100011, 3'd2, 1'b0, 4'd0, 0, "store");
    run_instr(7'b1101111, 3'd0, 1'b0, 4'd0, 0, "jal");
    run_instr(7'b0110111, 3'd0, 1'b0, 4'd0, 0, "lui");
    run_instr(7'b0010111, 3'd0, 1'b0, 4'd0, 0, "auipc");

    run_instr(7'b1100011, 3'd0, 1'b0, 4'b0100, 0, "beq_z");
    check("beq_taken", {50'd0, cap_pcw[2]}, 51'd1);
    run_instr(7'b1100011, 3'd1, 1'b0, 4'b0100, 0, "bne_z");
    check("bne_not_taken", {50'd0, cap_pcw[2]}, 51'd0);
    run_instr(7'b1100011, 3'd1, 1'b0, 4'b0000, 0, "bne_nz");
    run_instr(7'b1100011, 3'd4, 1'b0, 4'b1001, 0, "blt_nv");
    check("blt_not_taken", {50'd0, cap_pcw[2]}, 51'd0);
    run_instr(7'b1100011, 3'd4, 1'b0, 4'b1000, 0, "blt_n");
    run_instr(7'b1100011, 3'd5, 1'b0, 4'b1000, 0, "bge_n");
    check("bge_not_taken", {50'd0, cap_pcw[2]}, 51'd0);
    run_instr(7'b1100011, 3'd5, 1'b0, 4'b0011, 0, "bge_cv");

    // reset in the middle of a store's MEMWRITE
    run_instr(7'b0100011, 3'd2, 1'b0, 4'd0, 4, "store_cut");
    check("memwrite_before_reset", {50'd0, cap_mw[3]}, 51'd1);
    assert_reset("rst_mid_store");
    release_reset();

    // illegal opcode traps for good
    run_instr(7'b1111111, 3'd0, 1'b0, 4'd0, 0, "ill_op");
    idle(20, "ill_wait");
    #1 check("ill_flag", {50'd0, illegal}, 51'd1);
    check("ill_no_fetch", {50'd0, IRWrite}, 51'd0);
    assert_reset("rst_ill");
    release_reset();

    // unsupported branch funct3 also traps
    run_instr(7'b1100011, 3'd2, 1'b0, 4'd0, 0, "ill_br");
    idle(3, "ill_br_wait");
    assert_reset("rst_ill_br");

    // preload the counter to its maximum and retire across the wrap
    @(negedge clk);
    #1 reset = 1'b0;
    trapped = 0;
    tick();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    instret_m = 32'hFFFF_FFFF;
    push(19'd0, "wrap_rst");
    run_instr(7'b0010011, 3'd0, 1'b0, 4'd0, 0, "wrap_addi");
    check("wrap_pre", {19'd0, cap_inst[0]}, {19'd0, 32'hFFFF_FFFF});
    run_instr(7'b0110011, 3'd7, 1'b0, 4'd0, 0, "wrap_and");
    check("wrap_zero", {19'd0, cap_inst[0]}, 51'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
